bin_display_emitter: RTL



---
 rtl/bin_display_pkg.sv | 22 ++
 rtl/bin_display_emitter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/bin_display_pkg.sv
// Shared types and ASCII constants for the binary-to-text line emitter.
package bin_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_EQUALS,
    ST_DIGITS,
    ST_EOL
  } state_t;

  localparam logic [7:0] ASC_ZERO = 8'h30;
  localparam logic [7:0] ASC_ONE  = 8'h31;
  localparam logic [7:0] ASC_EQ   = 8'h3D;
  localparam logic [7:0] ASC_LF   = 8'h0A;

  function automatic int bytes_per_line(input int width, input int prefix_len,
                                        input int newline);
    return prefix_len + 1 + width + newline;
  endfunction

endpackage

// File: rtl/bin_display_emitter.sv
// Emits "label=0101..\n" for each accepted word as a valid/ready byte stream.
module bin_display_emitter
  import bin_display_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PREFIX_LEN = 4,
  parameter int NEWLINE    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [WIDTH-1:0]                              in_value,
  input  logic [((PREFIX_LEN > 0) ? 8*PREFIX_LEN : 8)-1:0] in_prefix,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [7:0]                                    out_byte,
  output logic                                          out_last,
  output logic                                          busy,
  output logic [CNT_W-1:0]                              line_count
);

  localparam int PW   = (PREFIX_LEN > 0) ? 8*PREFIX_LEN : 8;
  localparam int PI_W = (PREFIX_LEN > 0) ? $clog2(PREFIX_LEN + 1) : 1;
  localparam int DI_W = $clog2(WIDTH + 1);
  localparam logic [PI_W-1:0] PIDX_LAST = PI_W'(PREFIX_LEN - 1);
  localparam logic [DI_W-1:0] DIDX_TOP  = DI_W'(WIDTH - 1);

  state_t            state, state_nxt;
  logic [PI_W-1:0]   pidx, pidx_nxt;
  logic [DI_W-1:0]   didx, didx_nxt;
  logic [WIDTH-1:0]  value_q, value_src;
  logic [PW-1:0]     prefix_q, prefix_src;
  logic              capture, xfer;
  logic [7:0]        byte_nxt;
  logic              last_nxt;
  logic              valid_nxt;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign xfer     = out_valid && out_ready;

  always_comb begin
    state_nxt  = state;
    pidx_nxt   = pidx;
    didx_nxt   = didx;
    capture    = 1'b0;
    byte_nxt   = 8'h00;
    last_nxt   = 1'b0;
    valid_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          capture   = 1'b1;
          pidx_nxt  = '0;
          didx_nxt  = DIDX_TOP;
          state_nxt = (PREFIX_LEN > 0) ? ST_PREFIX : ST_EQUALS;
        end
      end
      ST_PREFIX: begin
        if (xfer) begin
          if (pidx == PIDX_LAST) state_nxt = ST_EQUALS;
          else                   pidx_nxt  = pidx + PI_W'(1);
        end
      end
      ST_EQUALS: begin
        if (xfer) begin
          state_nxt = ST_DIGITS;
          didx_nxt  = DIDX_TOP;
        end
      end
      ST_DIGITS: begin
        if (xfer) begin
          if (didx == '0) state_nxt = (NEWLINE != 0) ? ST_EOL : ST_IDLE;
          else            didx_nxt  = didx - DI_W'(1);
        end
      end
      ST_EOL: begin
        if (xfer) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The byte register is loaded with the character for the upcoming state, so
    // on the accept edge the live inputs stand in for the not-yet-written copies.
    value_src  = capture ? in_value  : value_q;
    prefix_src = capture ? in_prefix : prefix_q;

    valid_nxt = (state_nxt != ST_IDLE);
    case (state_nxt)
      ST_PREFIX: begin
        for (int i = 0; i < PW/8; i++) begin
          if (pidx_nxt == PI_W'(i)) byte_nxt = prefix_src[PW-1-8*i -: 8];
        end
      end
      ST_EQUALS: byte_nxt = ASC_EQ;
      ST_DIGITS: begin
        byte_nxt = (|(value_src & (WIDTH'(1) << didx_nxt))) ? ASC_ONE : ASC_ZERO;
        last_nxt = (NEWLINE == 0) && (didx_nxt == '0);
      end
      ST_EOL: begin
        byte_nxt = ASC_LF;
        last_nxt = 1'b1;
      end
      default: byte_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      pidx       <= '0;
      didx       <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_byte   <= 8'h00;
      line_count <= '0;
    end else begin
      state     <= state_nxt;
      pidx      <= pidx_nxt;
      didx      <= didx_nxt;
      out_valid <= valid_nxt;
      out_last  <= last_nxt;
      out_byte  <= byte_nxt;
      if (xfer && out_last) line_count <= line_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      value_q  <= in_value;
      prefix_q <= in_prefix;
    end
  end

endmodule
